// File: rtl/center_of_mass.sv
// Streaming mask centroid: accumulates x/y/count per frame, then runs two
// restoring dividers. Define COM_ROUND_EN for round-half-up quotients.

module com_div_lane #(
  parameter int W  = 32,
  parameter int QW = 11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  num,
  input  logic [W-1:0]  den,
  output logic [QW-1:0] quo
);
  logic [W-1:0] rem, q;
  logic [W:0]   trial, diff;
  logic         ge;

  // Numerator bits shift out of q's MSB as quotient bits shift into its LSB.
  assign trial = {rem, q[W-1]};
  assign diff  = trial - {1'b0, den};
  assign ge    = trial >= {1'b0, den};
  assign quo   = q[QW-1:0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem <= '0;
      q   <= '0;
    end else if (load) begin
      rem <= '0;
      q   <= num;
    end else if (step) begin
      q   <= {q[W-2:0], ge};
      rem <= ge ? diff[W-1:0] : trial[W-1:0];
    end
  end
endmodule

module center_of_mass #(
  parameter int ACC_WIDTH = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        tabulate_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out
);
  localparam int NUM_LANES = 2;
  localparam int IW        = $clog2(ACC_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t                               state;
  logic [IW-1:0]                        iter;
  logic [ACC_WIDTH-1:0]                 sum_x, sum_y, cnt, den;
  logic [ACC_WIDTH-1:0]                 px, py, tot_x, tot_y, tot_c, rnd;
  logic [NUM_LANES-1:0][ACC_WIDTH-1:0]  num;
  logic [10:0]                          x_q;
  logic [9:0]                           y_q;
  logic                                 accept, step;

  assign px    = valid_in ? {{(ACC_WIDTH-11){1'b0}}, x_in} : '0;
  assign py    = valid_in ? {{(ACC_WIDTH-10){1'b0}}, y_in} : '0;
  assign tot_x = sum_x + px;
  assign tot_y = sum_y + py;
  assign tot_c = cnt + {{(ACC_WIDTH-1){1'b0}}, valid_in};

`ifdef COM_ROUND_EN
  assign rnd = tot_c >> 1;
`else
  assign rnd = '0;
`endif

  assign num[0] = tot_x + rnd;
  assign num[1] = tot_y + rnd;
  assign accept = (state == IDLE) && tabulate_in && (tot_c != '0);
  assign step   = (state == DIVIDE) && (iter != IW'(ACC_WIDTH));

  // A pixel on the accepting edge counts in this frame and seeds the next one.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
      den   <= '0;
    end else if (accept) begin
      sum_x <= px;
      sum_y <= py;
      cnt   <= {{(ACC_WIDTH-1){1'b0}}, valid_in};
      den   <= tot_c;
    end else begin
      sum_x <= tot_x;
      sum_y <= tot_y;
      cnt   <= tot_c;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    if (g == 0) begin : g_x
      com_div_lane #(.W(ACC_WIDTH), .QW(11)) u_div (
        .clk_in(clk_in), .rst_in(rst_in), .load(accept), .step(step),
        .num(num[g]), .den(den), .quo(x_q)
      );
    end else begin : g_y
      com_div_lane #(.W(ACC_WIDTH), .QW(10)) u_div (
        .clk_in(clk_in), .rst_in(rst_in), .load(accept), .step(step),
        .num(num[g]), .den(den), .quo(y_q)
      );
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      iter      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          if (accept) begin
            state <= DIVIDE;
            iter  <= '0;
          end
        end
        DIVIDE: begin
          if (iter == IW'(ACC_WIDTH)) begin
            state     <= DONE;
            x_out     <= x_q;
            y_out     <= y_q;
            valid_out <= 1'b1;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          valid_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_center_of_mass.sv
// Table-driven frames plus hand sequences; a behavioural model pushes expected
// centroids at acceptance and the monitor pops them on valid_out.

module tb_center_of_mass;
  localparam int W = 32;

  logic        clk_in = 0, rst_in = 1;
  logic [10:0] x_in = 0;
  logic [9:0]  y_in = 0;
  logic        valid_in = 0, tabulate_in = 0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;

  center_of_mass #(.ACC_WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [10:0] x; logic [9:0] y; int acc; } exp_t;
  typedef struct { int n; int xm; int ym; int ex; int ey; } vec_t;

  exp_t q[$];
  int   checks = 0, errors = 0, n_vld = 0, cyc = 0, idle_at = 0;

  logic [W-1:0] m_sx = 0, m_sy = 0, m_cnt = 0, t_sx, t_sy, t_cnt, rnd;
  logic [W-1:0] e_x, e_y;

  always_comb begin
    t_cnt = m_cnt + (valid_in ? 32'd1 : 32'd0);
    t_sx  = m_sx + (valid_in ? {21'd0, x_in} : 32'd0);
    t_sy  = m_sy + (valid_in ? {22'd0, y_in} : 32'd0);
`ifdef COM_ROUND_EN
    rnd = t_cnt / 2;
`else
    rnd = 32'd0;
`endif
    e_x = (t_cnt == 0) ? 32'd0 : (t_sx + rnd) / t_cnt;
    e_y = (t_cnt == 0) ? 32'd0 : (t_sy + rnd) / t_cnt;
  end

  // Reference model: idle again W+3 edges after an acceptance.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (rst_in) begin
      m_sx <= 0; m_sy <= 0; m_cnt <= 0; idle_at <= 0;
      q.delete();
    end else if (cyc >= idle_at && tabulate_in && t_cnt != 0) begin
      q.push_back('{e_x[10:0], e_y[9:0], cyc});
      m_sx    <= valid_in ? {21'd0, x_in} : 32'd0;
      m_sy    <= valid_in ? {22'd0, y_in} : 32'd0;
      m_cnt   <= valid_in ? 32'd1 : 32'd0;
      idle_at <= cyc + W + 3;
    end else begin
      m_sx <= t_sx; m_sy <= t_sy; m_cnt <= t_cnt;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (valid_out === 1'b1) begin
      n_vld++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got valid_out=1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_x", x_out, e.x);
        check("sb_y", y_out, e.y);
        check("latency", cyc - 1 - e.acc, W + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    rst_in = 1; valid_in = 0; tabulate_in = 0;
    tick(); tick();
    rst_in = 0;
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_valid", valid_out, 0);
  endtask

  task automatic run_frame(input int n, input int xm, input int ym);
    for (int i = 0; i < n; i++) begin
      valid_in = 1;
      x_in = (xm < 0) ? 11'(i) : 11'(xm);
      y_in = (ym == -1) ? 10'(i) : (ym == -2) ? 10'(i / 2) : 10'(ym);
      tick();
    end
    valid_in = 0; tabulate_in = 1;
    tick();
    tabulate_in = 0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && q.size() != 0; k++) tick();
    check({nm, "_drain_pending"}, q.size(), 0);
  endtask

  vec_t tbl[3];
  int   base;

  initial begin
`ifdef COM_ROUND_EN
    tbl[0] = '{1000, -1, -2, 500, 250};
    tbl[1] = '{800, 100, -2, 100, 200};
    tbl[2] = '{600, -1, 50, 300, 50};
`else
    tbl[0] = '{1000, -1, -2, 499, 249};
    tbl[1] = '{800, 100, -2, 100, 199};
    tbl[2] = '{600, -1, 50, 299, 50};
`endif

    for (int t = 0; t < 3; t++) begin
      do_reset();
      base = n_vld;
      run_frame(tbl[t].n, tbl[t].xm, tbl[t].ym);
      drain("frame");
      check("tbl_x", x_out, tbl[t].ex);
      check("tbl_y", y_out, tbl[t].ey);
      check("tbl_pulses", n_vld - base, 1);
    end

    // Empty tabulate after a frame: outputs hold, no pulse.
    base = n_vld;
    tabulate_in = 1; tick(); tabulate_in = 0;
    repeat (W + 10) tick();
    check("empty_hold_x", x_out, tbl[2].ex);
    check("empty_pulses", n_vld - base, 0);

    // Reset mid-division aborts the pending result.
    run_frame(50, -1, 7);
    repeat (10) tick();
    rst_in = 1; #1;
    check("abort_x", x_out, 0);
    check("abort_y", y_out, 0);
    tick(); rst_in = 0;
    base = n_vld;
    repeat (W + 10) tick();
    check("abort_pulses", n_vld - base, 0);

    // Empty tabulate straight after reset.
    do_reset();
    tabulate_in = 1; tick(); tabulate_in = 0;
    repeat (W + 10) tick();
    check("empty_rst_x", x_out, 0);
    check("empty_rst_y", y_out, 0);

    // valid_in and tabulate_in held high together: retriggers every return to IDLE.
    do_reset();
    base = n_vld;
    valid_in = 1; tabulate_in = 1; x_in = 200; y_in = 100;
    repeat (3 * (W + 3) + 5) tick();
    valid_in = 0; tabulate_in = 0;
    drain("held");
    check("held_pulses_ge3", (n_vld - base) >= 3, 1);
    check("held_x", x_out, 200);
    check("held_y", y_out, 100);
    tabulate_in = 1; tick(); tabulate_in = 0;
    drain("held_tail");
    run_frame(4, 7, -1);
    drain("after_held");
    check("after_x", x_out, 7);
`ifdef COM_ROUND_EN
    check("after_y", y_out, 2);
`else
    check("after_y", y_out, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/center_of_mass.md
Name: center_of_mass

Overview:
Streaming centroid unit for the hand-gesture pipeline. It accumulates the x/y coordinates and the count of every qualifying pixel (valid_in) across a frame. On tabulate_in it divides the sums by the count to produce the mask's centre of mass. It sits between the colour/threshold mask stage and the gesture/crosshair logic.

Parameters:
ACC_WIDTH, 32, width of sum_x, sum_y, pixel count and divider datapath; must be >= 31 for 2047 x 2^20 worst case.

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_in  input  1  asynchronous, active-high reset
x_in  input  11  pixel x coordinate, sampled when valid_in=1
y_in  input  10  pixel y coordinate, sampled when valid_in=1
valid_in  input  1  pixel belongs to mask; accumulate this cycle
tabulate_in  input  1  end-of-frame request: compute centroid of accumulated pixels
x_out  output  11  centroid x, floor(sum_x/count)
y_out  output  10  centroid y, floor(sum_y/count)
valid_out  output  1  one-cycle pulse; x_out/y_out are new

Behaviour:
- Reset (async, rst_in=1): sum_x, sum_y, count = 0. State = IDLE. x_out = 0, y_out = 0, valid_out = 0. Reset mid-division aborts it; no valid_out is produced.
- Accumulate: on every edge with valid_in=1: sum_x += x_in, sum_y += y_in, count += 1. This is independent of state. Sums wrap modulo 2^ACC_WIDTH; no saturation.
- States: IDLE, DIVIDE, DONE.
- Tabulate acceptance: tabulate_in is a level, sampled only in IDLE.
  - If count != 0 (including a pixel accepted on the same edge), the edge's totals are copied into the divider operands and the accumulators restart from zero, or from that pixel if valid_in is also high.
  - State then goes to DIVIDE.
  - If the resulting count is 0, tabulate is ignored: stay IDLE, no valid_out.
- Pixels arriving while in DIVIDE/DONE accumulate into the next frame. tabulate_in outside IDLE is ignored.
- DIVIDE: two parallel restoring radix-2 dividers (sum_x/count, sum_y/count), one quotient bit per cycle, ACC_WIDTH iterations.
- Latency: with acceptance at edge N, iterations occur on edges N+1..N+ACC_WIDTH. At edge N+ACC_WIDTH+1 (state DONE), x_out/y_out are registered and valid_out=1 for exactly one cycle. The next edge returns to IDLE with valid_out=0.
- Quotients are truncated to 11/10 LSBs; they always fit for real frames.
- x_out/y_out hold their last value until the next valid_out.
- tabulate_in held high continuously retriggers on every return to IDLE with count != 0.

Optional Feature:
COM_ROUND_EN: when defined, numerators get floor(count/2) added before division, giving round-half-up results (e.g. 249.5 -> 250). When undefined, quotients truncate (249.5 -> 249). Latency is identical either way.

Test Plan:
- Reset; 1000 pixels x=i, y=i/2 (i=0..999), then tabulate -> count 1000, single valid_out pulse ACC_WIDTH+1 cycles after acceptance, x_out=499, y_out=249 (250 with COM_ROUND_EN).
- Reset; 800 pixels x=100, y=i/2 -> x_out=100, y_out=199 (200 rounded).
- Reset; 600 pixels x=i, y=50 -> x_out=299 (300 rounded), y_out=50.
- Reset; single pixel (200,100) with valid_in and tabulate_in both held high -> every result is x_out=200, y_out=100; the same-cycle pixel is included; subsequent frames restart cleanly.
- Tabulate with no pixels since reset/last tabulate -> no valid_out, outputs unchanged (0 after reset).
- Assert rst_in during DIVIDE -> outputs 0 immediately; no valid_out pulse afterwards.
